// File: rtl/sram_march_bist_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_march_bist_if
// Brief    : Control, result and shared SRAM port-0 bundle of the March BIST.
// Revision : 1.0 - initial release
// ============================================================================
interface sram_march_bist_if #(
    parameter int ADDR_SIZE  = 16,
    parameter int DATA_SIZE  = 32,
    parameter int WMASK_SIZE = 4,
    parameter int MAX_CHIPS  = 16
);
    logic                  start;
    logic [3:0]            sram_sel;
    logic [ADDR_SIZE-1:0]  addr_max;
    logic [DATA_SIZE-1:0]  data_bg;
    logic [DATA_SIZE-1:0]  rdata;

    logic [ADDR_SIZE-1:0]  addr0;
    logic [DATA_SIZE-1:0]  din0;
    logic                  web0;
    logic [WMASK_SIZE-1:0] wmask0;
    logic [MAX_CHIPS-1:0]  csb0;

    logic                  busy;
    logic                  done;
    logic                  pass;
    logic [15:0]           fail_count;
    logic [ADDR_SIZE-1:0]  first_fail_addr;
    logic [DATA_SIZE-1:0]  first_fail_data;

    modport master (
        input  start, sram_sel, addr_max, data_bg, rdata,
        output addr0, din0, web0, wmask0, csb0,
        output busy, done, pass, fail_count, first_fail_addr, first_fail_data
    );

    modport slave (
        output start, sram_sel, addr_max, data_bg, rdata,
        input  addr0, din0, web0, wmask0, csb0,
        input  busy, done, pass, fail_count, first_fail_addr, first_fail_data
    );
endinterface
`default_nettype wire

// File: rtl/sram_march_bist.sv
`default_nettype none
// ============================================================================
// Module   : sram_march_bist
// Brief    : March C- BIST sequencer driving one SRAM of a shared port-0 bank.
// Revision : 1.0 - initial release
// ============================================================================
module sram_march_bist #(
    parameter int ADDR_SIZE  = 16,
    parameter int DATA_SIZE  = 32,
    parameter int WMASK_SIZE = 4,
    parameter int MAX_CHIPS  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    sram_march_bist_if.master bus
);
    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_RUN       = 2'd1;
    localparam logic [1:0] c_DRAIN     = 2'd2;
    localparam logic [1:0] c_DONE      = 2'd3;
    localparam logic [2:0] c_LAST_ELEM = 3'd5;

    logic [1:0]            state_q, state_d;
    logic [2:0]            elem_q, elem_d;
    logic                  wr_q, wr_d;
    logic [ADDR_SIZE-1:0]  addr_q, addr_d;
    logic                  drain_q, drain_d;
    logic [3:0]            sel_q, sel_d;
    logic [ADDR_SIZE-1:0]  amax_q, amax_d;
    logic [DATA_SIZE-1:0]  pat_q, pat_d;

    logic [ADDR_SIZE-1:0]  addr0_q, addr0_d;
    logic [DATA_SIZE-1:0]  din0_q, din0_d;
    logic                  web0_q, web0_d;
    logic [WMASK_SIZE-1:0] wmask0_q, wmask0_d;
    logic [MAX_CHIPS-1:0]  csb0_q, csb0_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic [15:0]           fail_q, fail_d;
    logic [ADDR_SIZE-1:0]  ffa_q, ffa_d;
    logic [DATA_SIZE-1:0]  ffd_q, ffd_d;

    logic                  p1_v_q, p1_v_d, p2_v_q;
    logic [DATA_SIZE-1:0]  p1_exp_q, p1_exp_d, p2_exp_q;
    logic [ADDR_SIZE-1:0]  p1_addr_q, p1_addr_d, p2_addr_q;

    logic                  op_d;
    logic                  accept;
    logic                  finish;
    logic                  sel_ok;
    logic                  elem_down;
    logic                  last_addr;
    logic                  mismatch;

    assign sel_ok    = (32'(bus.sram_sel) < 32'(MAX_CHIPS));
    assign elem_down = (elem_q > 3'd2);
    // Element ends on an equality compare so addr_max = all ones never wraps.
    assign last_addr = elem_down ? (addr_q == '0) : (addr_q == amax_q);
    assign mismatch  = p2_v_q && (bus.rdata != p2_exp_q);

    // Sequencer: works out the op to present next cycle.
    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        drain_d = drain_q;
        sel_d   = sel_q;
        amax_d  = amax_q;
        pat_d   = pat_q;
        op_d    = 1'b0;
        accept  = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            c_IDLE: begin
                if (bus.start) begin
                    accept = 1'b1;
                    sel_d  = bus.sram_sel;
                    amax_d = bus.addr_max;
                    pat_d  = bus.data_bg;
                    if (sel_ok) begin
                        state_d = c_RUN;
                        elem_d  = 3'd0;
                        wr_d    = 1'b1;
                        addr_d  = '0;
                        op_d    = 1'b1;
                    end else begin
                        state_d = c_DONE;
                        finish  = 1'b1;
                    end
                end
            end
            c_RUN: begin
                op_d = 1'b1;
                if (!wr_q && (elem_q != c_LAST_ELEM)) begin
                    wr_d = 1'b1;
                end else if (!last_addr) begin
                    addr_d = elem_down ? (addr_q - ADDR_SIZE'(1)) : (addr_q + ADDR_SIZE'(1));
                    wr_d   = (elem_q == 3'd0);
                end else if (elem_q != c_LAST_ELEM) begin
                    elem_d = elem_q + 3'd1;
                    addr_d = (elem_q >= 3'd2) ? amax_q : '0;
                    wr_d   = 1'b0;
                end else begin
                    op_d    = 1'b0;
                    state_d = c_DRAIN;
                    drain_d = 1'b0;
                end
            end
            c_DRAIN: begin
                if (drain_q) begin
                    state_d = c_DONE;
                    finish  = 1'b1;
                end else begin
                    drain_d = 1'b1;
                end
            end
            c_DONE: begin
                state_d = c_IDLE;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    // Port drive, compare pipeline and result bookkeeping.
    always_comb begin
        addr0_d  = '0;
        din0_d   = '0;
        web0_d   = 1'b1;
        wmask0_d = '0;
        csb0_d   = '1;
        if (op_d) begin
            addr0_d  = addr_d;
            web0_d   = ~wr_d;
            wmask0_d = '1;
            csb0_d   = ~(MAX_CHIPS'(1) << sel_d);
            if (wr_d) begin
                din0_d = elem_d[0] ? ~pat_d : pat_d;
            end
        end

        // Odd elements read P, even elements read ~P.
        p1_v_d    = (state_q == c_RUN) && !wr_q;
        p1_exp_d  = elem_q[0] ? pat_q : ~pat_q;
        p1_addr_d = addr_q;

        fail_d = fail_q;
        ffa_d  = ffa_q;
        ffd_d  = ffd_q;
        if (mismatch) begin
            if (fail_q != 16'hFFFF) begin
                fail_d = fail_q + 16'd1;
            end
            if (fail_q == 16'd0) begin
                ffa_d = p2_addr_q;
                ffd_d = bus.rdata;
            end
        end

        busy_d = busy_q;
        done_d = 1'b0;
        pass_d = pass_q;
        if (accept) begin
            fail_d = '0;
            ffa_d  = '0;
            ffd_d  = '0;
            pass_d = 1'b0;
            busy_d = 1'b1;
        end
        if (finish) begin
            done_d = 1'b1;
            busy_d = 1'b0;
            pass_d = accept ? 1'b0 : (fail_d == 16'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= c_IDLE;
            elem_q    <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            drain_q   <= 1'b0;
            sel_q     <= '0;
            amax_q    <= '0;
            pat_q     <= '0;
            addr0_q   <= '0;
            din0_q    <= '0;
            web0_q    <= 1'b1;
            wmask0_q  <= '0;
            csb0_q    <= '1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= '0;
            ffa_q     <= '0;
            ffd_q     <= '0;
            p1_v_q    <= 1'b0;
            p1_exp_q  <= '0;
            p1_addr_q <= '0;
            p2_v_q    <= 1'b0;
            p2_exp_q  <= '0;
            p2_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            elem_q    <= elem_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            drain_q   <= drain_d;
            sel_q     <= sel_d;
            amax_q    <= amax_d;
            pat_q     <= pat_d;
            addr0_q   <= addr0_d;
            din0_q    <= din0_d;
            web0_q    <= web0_d;
            wmask0_q  <= wmask0_d;
            csb0_q    <= csb0_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            ffa_q     <= ffa_d;
            ffd_q     <= ffd_d;
            p1_v_q    <= p1_v_d;
            p1_exp_q  <= p1_exp_d;
            p1_addr_q <= p1_addr_d;
            p2_v_q    <= p1_v_q;
            p2_exp_q  <= p1_exp_q;
            p2_addr_q <= p1_addr_q;
        end
    end

    assign bus.addr0           = addr0_q;
    assign bus.din0            = din0_q;
    assign bus.web0            = web0_q;
    assign bus.wmask0          = wmask0_q;
    assign bus.csb0            = csb0_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.pass            = pass_q;
    assign bus.fail_count      = fail_q;
    assign bus.first_fail_addr = ffa_q;
    assign bus.first_fail_data = ffd_q;
endmodule
`default_nettype wire
